// File: rtl/noc_rr_arbiter.sv
// N-requester switch-allocation arbiter: fixed-priority or round-robin,
// registered one-hot grant with encoded index, and a lock that holds a grant across a packet.
module noc_rr_arbiter #(
   parameter int N_REQ   = 4,
   parameter bit RR_MODE = 1'b1,
   localparam int IDX_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [N_REQ-1:0] req_i,
   input  logic             lock_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             valid_o
);

   localparam int unsigned N_U = N_REQ;

   typedef enum logic [1:0] {
      D_IDLE,
      D_HOLD,
      D_ARB
   } decision_e;

   decision_e        decision;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             valid_q, valid_d;

   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   int unsigned      scan_base;
   int unsigned      cand;

   // Scan starts at ptr_q in round-robin mode and at 0 in fixed mode; first hit wins.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      scan_base = RR_MODE ? int'(ptr_q) : 0;
      for (int unsigned i = 0; i < N_U; i++) begin
         cand = scan_base + i;
         if (cand >= N_U) cand = cand - N_U;
         if (!win_found && req_i[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // A dropped granted request overrides lock_i and falls straight into arbitration.
   always_comb begin
      decision = D_IDLE;
      grant_d  = grant_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      valid_d  = valid_q;

      if (valid_q && lock_i && req_i[idx_q]) begin
         decision = D_HOLD;
      end else if (win_found) begin
         decision = D_ARB;
      end

      case (decision)
         D_ARB: begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            idx_d            = win_idx;
            valid_d          = 1'b1;
            if (RR_MODE) begin
               ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         D_IDLE: begin
            grant_d = '0;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_idx_o = idx_q;
   assign valid_o     = valid_q;

   a_onehot0 : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(grant_q));
   a_valid   : assert property (@(posedge clk) disable iff (!arst_n) valid_q == (|grant_q));

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus and are
// compared each cycle against a distance-based reference model of the arbitration rules.
module tb_noc_rr_arbiter;

   logic       clk;
   logic       arst_n;
   logic [3:0] req;
   logic       lock;

   logic [3:0] g_rr, g_fx;
   logic [1:0] i_rr, i_fx;
   logic       v_rr, v_fx;

   int checks;
   int errors;

   // Model state, index 0 = fixed priority, index 1 = round-robin.
   int m_idx   [2];
   int m_ptr   [2];
   bit m_valid [2];

   noc_rr_arbiter #(.N_REQ(4), .RR_MODE(1'b1)) dut_rr (
      .clk(clk), .arst_n(arst_n), .req_i(req), .lock_i(lock),
      .grant_o(g_rr), .grant_idx_o(i_rr), .valid_o(v_rr)
   );

   noc_rr_arbiter #(.N_REQ(4), .RR_MODE(1'b0)) dut_fx (
      .clk(clk), .arst_n(arst_n), .req_i(req), .lock_i(lock),
      .grant_o(g_fx), .grant_idx_o(i_fx), .valid_o(v_fx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_idx[m]   = 0;
         m_ptr[m]   = 0;
         m_valid[m] = 1'b0;
      end
   endtask

   // Winner = requester with smallest priority distance (index in fixed mode,
   // distance from the pointer going upward in round-robin mode).
   task automatic model_update(input logic [3:0] r, input logic l);
      int best, bestd, d;
      for (int m = 0; m < 2; m++) begin
         if (m_valid[m] && l && r[m_idx[m]]) continue;
         if (r == 4'b0000) begin
            m_valid[m] = 1'b0;
            continue;
         end
         best  = -1;
         bestd = 99;
         for (int k = 0; k < 4; k++) begin
            if (r[k]) begin
               d = (m == 1) ? (k - m_ptr[m] + 4) % 4 : k;
               if (d < bestd) begin
                  bestd = d;
                  best  = k;
               end
            end
         end
         m_idx[m]   = best;
         m_valid[m] = 1'b1;
         if (m == 1) m_ptr[m] = (best + 1) % 4;
      end
   endtask

   function automatic logic [6:0] exp_vec(input int m);
      logic [3:0] g;
      g = m_valid[m] ? (4'b0001 << m_idx[m]) : 4'b0000;
      return {g, 2'(m_idx[m]), m_valid[m]};
   endfunction

   task automatic step(input logic [3:0] r, input logic l);
      req  = r;
      lock = l;
      @(posedge clk);
      model_update(r, l);
      #1;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      #2;
      model_reset();
      arst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) step(4'b1111, 1'b1);
      #2;
      arst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({g_rr, i_rr, v_rr} !== 7'b0) begin
         errors++;
         $display("FAIL reset_rr: got %b expected %b", {g_rr, i_rr, v_rr}, 7'b0);
      end
      checks++;
      if ({g_fx, i_fx, v_fx} !== 7'b0) begin
         errors++;
         $display("FAIL reset_fx: got %b expected %b", {g_fx, i_fx, v_fx}, 7'b0);
      end
      #2;
      arst_n = 1'b1;
      step(4'b1111, 1'b1);
      checks++;
      if (g_rr !== 4'b0001 || g_fx !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant: got rr=%b fx=%b expected 0001", g_rr, g_fx);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         step(4'b1010, 1'b0);
         checks++;
         if (g_fx !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_hold cyc%0d: got %b expected 0010", c, g_fx);
         end
         checks++;
         if ({g_rr, i_rr, v_rr} !== exp_vec(1)) begin
            errors++;
            $display("FAIL fixed_rr_side cyc%0d: got %b expected %b", c, {g_rr, i_rr, v_rr}, exp_vec(1));
         end
      end
      step(4'b1000, 1'b0);
      checks++;
      if (g_fx !== 4'b1000) begin
         errors++;
         $display("FAIL fixed_drop: got %b expected 1000", g_fx);
      end
   endtask

   task automatic test_rr_rotation();
      logic [1:0] seq [5];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step(4'b1111, 1'b0);
         checks++;
         if (i_rr !== seq[c] || v_rr !== 1'b1) begin
            errors++;
            $display("FAIL rr_rotate cyc%0d: got idx=%0d valid=%b expected idx=%0d valid=1", c, i_rr, v_rr, seq[c]);
         end
         checks++;
         if ({g_fx, i_fx, v_fx} !== exp_vec(0)) begin
            errors++;
            $display("FAIL rr_rotate_fx cyc%0d: got %b expected %b", c, {g_fx, i_fx, v_fx}, exp_vec(0));
         end
      end
   endtask

   task automatic test_rr_wrap();
      logic [1:0] seq [3];
      seq = '{2'd0, 2'd2, 2'd0};
      do_reset();
      step(4'b0100, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(4'b0101, 1'b0);
         checks++;
         if (i_rr !== seq[c] || {g_rr, i_rr, v_rr} !== exp_vec(1)) begin
            errors++;
            $display("FAIL rr_wrap cyc%0d: got idx=%0d grant=%b expected idx=%0d", c, i_rr, g_rr, seq[c]);
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      step(4'b0011, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(4'b0011, 1'b1);
         checks++;
         if (g_rr !== 4'b0001 || g_fx !== 4'b0001) begin
            errors++;
            $display("FAIL lock_hold cyc%0d: got rr=%b fx=%b expected 0001", c, g_rr, g_fx);
         end
      end
      step(4'b0011, 1'b0);
      checks++;
      if (g_rr !== 4'b0010) begin
         errors++;
         $display("FAIL lock_release: got %b expected 0010", g_rr);
      end
      checks++;
      if (g_fx !== 4'b0001) begin
         errors++;
         $display("FAIL lock_release_fx: got %b expected 0001", g_fx);
      end
   endtask

   task automatic test_lock_break();
      do_reset();
      step(4'b0101, 1'b0);
      step(4'b0101, 1'b1);
      step(4'b0100, 1'b1);
      checks++;
      if (g_rr !== 4'b0100 || g_fx !== 4'b0100) begin
         errors++;
         $display("FAIL lock_break: got rr=%b fx=%b expected 0100", g_rr, g_fx);
      end
      step(4'b0000, 1'b1);
      checks++;
      if ({g_rr, i_rr, v_rr} !== 7'b0000_10_0 || {g_fx, i_fx, v_fx} !== 7'b0000_10_0) begin
         errors++;
         $display("FAIL lock_break_idle: got rr=%b fx=%b expected 0000100",
                  {g_rr, i_rr, v_rr}, {g_fx, i_fx, v_fx});
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       l;
      r = 4'b0000;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
         l = ($urandom_range(0, 2) != 0);
         step(r, l);
         checks++;
         if ({g_rr, i_rr, v_rr} !== exp_vec(1)) begin
            errors++;
            $display("FAIL random_rr cyc%0d req=%b lock=%b: got %b expected %b",
                     c, r, l, {g_rr, i_rr, v_rr}, exp_vec(1));
         end
         checks++;
         if ({g_fx, i_fx, v_fx} !== exp_vec(0)) begin
            errors++;
            $display("FAIL random_fx cyc%0d req=%b lock=%b: got %b expected %b",
                     c, r, l, {g_fx, i_fx, v_fx}, exp_vec(0));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      arst_n = 1'b0;
      req    = 4'b0000;
      lock   = 1'b0;
      model_reset();
      #12;
      arst_n = 1'b1;
      test_reset();
      test_fixed_priority();
      test_rr_rotation();
      test_rr_wrap();
      test_lock();
      test_lock_break();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Parametrised N-requester arbiter for the router input-to-output switch allocation path. Successor to the 2-input fixed-priority arbiter: selectable fixed-priority or round-robin mode, registered one-hot grant with encoded index, and a lock input that holds a grant across a multi-flit (wormhole) packet. One instance per router output port, fed by the per-input-port request lines for that output.

## Interface
- N_REQ, 4, number of requesters; legal range 2..16
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)
- IDX_W, $clog2(N_REQ), width of encoded grant index; derived, not overridden

- clk  input  1  single clock, all state on rising edge
- arst_n  input  1  asynchronous active-low reset
- req_i  input  N_REQ  request vector, bit k = requester k
- lock_i  input  1  hold current grant (packet in progress, high until tail flit accepted)
- grant_o  output  N_REQ  registered one-hot grant; all-zero = no grant
- grant_idx_o  output  IDX_W  index of granted requester; valid only when valid_o=1
- valid_o  output  1  registered, equals OR of grant_o

## Operation
- State: grant_q (N_REQ, one-hot or zero), ptr_q (IDX_W, round-robin highest-priority index), plus encoded index and valid registers.
- Reset (arst_n low, asynchronous): grant_o=0, grant_idx_o=0, valid_o=0, ptr_q=0. Outputs leave reset values on the first rising clk after arst_n deasserts.
- Per-cycle decision, priority order:
  1. HOLD: valid_o=1 and lock_i=1 and req_i[grant_idx_o]=1 -> all registers keep value.
  2. ARBITRATE: otherwise, select winner k among set bits of req_i. Fixed mode: lowest set index. RR mode: first set bit scanning ptr_q, ptr_q+1, ..., wrapping modulo N_REQ. Next grant_q = one-hot(k), grant_idx_o=k, valid_o=1.
  3. IDLE: req_i=0 -> grant_q=0, valid_o=0, grant_idx_o keeps old value, ptr_q unchanged.
- Pointer update (RR only): on every ARBITRATE cycle producing winner k, ptr_q <= (k+1) mod N_REQ; wrap from N_REQ-1 to 0. No update during HOLD or IDLE. Fixed mode: ptr_q stays 0.
- Lock release: dropping the granted request overrides lock_i; the arbiter re-arbitrates in that same cycle (next winner visible next cycle, no bubble if another request is pending).
- lock_i with valid_o=0 has no effect; a lock never forms before a grant is registered.
- Re-arbitration occurs every unlocked cycle, so with lock_i=0 RR alternates among continuous requesters per flit.
- grant_o always one-hot or zero; never multi-hot.

## Timing
- Request-to-grant latency: 1 cycle (req_i sampled at edge n, grant_o valid after edge n).
- Grant removal: 1 cycle after the granted req_i deasserts (if no other requester).
- Lock hold: grant stable for every cycle where lock_i=1 and the granted request stays high; released grant changes at the edge after lock_i or request falls.
- Reset mid-packet: asynchronous clear regardless of lock_i; first post-reset grant follows ptr_q=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert arst_n=0 mid-cycle with req_i=4'b1111, lock_i=1 -> grant_o=0, valid_o=0, grant_idx_o=0 immediately; after release first grant is 4'b0001.
- Fixed priority (RR_MODE=0, N_REQ=4): req_i=4'b1010 held 4 cycles -> grant_o=4'b0010 every cycle; drop bit1 -> grant_o=4'b1000 next cycle.
- Round-robin rotation (RR_MODE=1, N_REQ=4): req_i=4'b1111, lock_i=0 for 5 cycles -> grant_idx_o sequence 0,1,2,3,0.
- RR skip/wrap: ptr_q=3, req_i=4'b0101 -> grant_idx_o=0, then 2, then 0.
- Lock: req_i=4'b0011, lock_i=1 for 3 cycles after grant to 0 -> grant_o=4'b0001 held 3 cycles; lock_i=0 -> grant_o=4'b0010 next cycle.
- Lock broken by request drop: granted req0 falls while lock_i=1 and req_i[2]=1 -> grant_o=4'b0100 next edge; all requests low -> valid_o=0, grant_o=0.
